// File: rtl/speck_block_fifo.sv
// speck_block_fifo
// ----------------
// First-word-fall-through FIFO for Speck cipher blocks. It sits between a
// Speck datapath producer and its consumer, and decouples their rates.
//
// Ports
//   clk        sole clock; all state changes happen on the rising edge
//   reset      synchronous, active-low reset
//   in1        block to enqueue
//   ld         active-low write strobe (low = enqueue in1)
//   rd         active-high read strobe; pops the head entry
//   flush      active-high synchronous clear of contents and error flags
//   out        head entry (first-word-fall-through); 0 when empty
//   out_valid  high while the FIFO holds at least one entry
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   count      current occupancy, 0..DEPTH
//   ovf        sticky overflow flag (write dropped while full)
//   udf        sticky underflow flag (read requested while empty)
//
// Parameters
//   BLOCK_W    cipher block width (64 for Speck64, 128 for Speck128)
//   DEPTH      number of entries; power of two, at least 2
//   AW         pointer width, derived from DEPTH

module speck_block_fifo #(
    parameter int  BLOCK_W = 64,
    parameter int  DEPTH   = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] in1,
    input  logic               ld,
    input  logic               rd,
    input  logic               flush,
    output logic [BLOCK_W-1:0] out,
    output logic               out_valid,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count,
    output logic               ovf,
    output logic               udf
);

    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
    localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);

    // Storage and bookkeeping registers
    logic [BLOCK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      rp_q, rp_d;
    logic [AW:0]        count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic               rdFire;
    logic               wrFire;
    logic               memWrEn;

    // Status decode, handshake qualification and next-state computation.
    // A write into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle, which gives one-in/one-out pass-through at full.
    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        empty   = (count_q == '0);
        full    = (count_q == FullCount);
        rdFire  = rd && !empty;
        wrFire  = !ld && (!full || rdFire);
        memWrEn = wrFire && !flush;

        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wrFire) begin
                wp_d = wp_q + PtrOne;
            end
            if (rdFire) begin
                rp_d = rp_q + PtrOne;
            end
            if (wrFire && !rdFire) begin
                count_d = count_q + CountOne;
            end else if (rdFire && !wrFire) begin
                count_d = count_q - CountOne;
            end
            if (!ld && full && !rdFire) begin
                ovf_d = 1'b1;
            end
            if (rd && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    // Pointer, occupancy and flag registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Data array has no reset; stale entries are hidden by the empty gating
    // on the output mux. Writes are suppressed while reset is held low.
    always_ff @(posedge clk) begin
        if (reset && memWrEn) begin
            mem_q[wp_q] <= in1;
        end
    end

    // Head-of-queue output, driven only from registered state so in1 has
    // no combinational path to out
    always_comb begin
        out       = empty ? '0 : mem_q[rp_q];
        out_valid = !empty;
        count     = count_q;
        ovf       = ovf_q;
        udf       = udf_q;
    end

endmodule
